// File: rtl/pcs_receive_pipe.sv
// pcs_receive_pipe
// 1000BASE-X PCS receive path. It takes decoded code-groups (SUDI) and
// produces the GMII receive signals RX_DV, RX_ER and RXD. The decoder
// follows carrier detection, frame start, data, end-of-packet,
// carrier-extend and false-carrier rules. The FSM registers its emission,
// and PIPE further register stages follow it. The result for the SUDI
// sampled at edge n becomes visible after edge n+PIPE.
//
// Optional feature: define PCS_RX_STATS_EN to build saturating frame and
// error counters. When it is undefined, frame_count and error_count are
// tied to zero and no counter logic is built.
//
// Legal PIPE range is 1..4.

module pcs_receive_pipe #(
    parameter int PIPE  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_status,
    input  logic [10:0]      SUDI,
    output logic             RX_DV,
    output logic             RX_ER,
    output logic [7:0]       RXD,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count
);

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        IDLE,
        RECEIVE,
        EARLY_END,
        TRR_EXTEND,
        FALSE_CARRIER
    } state_t;

    // Special octets carried with the K flag
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_START = 8'hFB;
    localparam logic [7:0] OCT_TERM  = 8'hFD;
    localparam logic [7:0] OCT_EXT   = 8'hF7;

    // GMII substitution values
    localparam logic [7:0] RXD_PREAMBLE   = 8'h55;
    localparam logic [7:0] RXD_FALSE_CARR = 8'h0E;
    localparam logic [7:0] RXD_CARR_EXT   = 8'h0F;

    logic       evenFlag;
    logic       invalidFlag;
    logic       kFlag;
    logic [7:0] octet;

    logic isIdleK;
    logic isStart;
    logic isTerm;
    logic isExtend;
    logic isData;

    state_t     state_q;
    logic       dv_q;
    logic       er_q;
    logic [7:0] rxd_q;

    logic       dvPipe_q  [PIPE];
    logic       erPipe_q  [PIPE];
    logic [7:0] rxdPipe_q [PIPE];

    assign evenFlag    = SUDI[10];
    assign invalidFlag = SUDI[9];
    assign kFlag       = SUDI[8];
    assign octet       = SUDI[7:0];

    // An invalid code-group never counts as a recognised special code
    assign isIdleK  = !invalidFlag && kFlag && (octet == OCT_K28_5);
    assign isStart  = !invalidFlag && kFlag && (octet == OCT_START);
    assign isTerm   = !invalidFlag && kFlag && (octet == OCT_TERM);
    assign isExtend = !invalidFlag && kFlag && (octet == OCT_EXT);
    assign isData   = !invalidFlag && !kFlag;

    // Receive FSM: the state and the registered GMII emission for the code-group seen this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LINK_FAILED;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            rxd_q   <= 8'h00;
        end else begin
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            rxd_q <= 8'h00;
            if (!sync_status) begin
                state_q <= LINK_FAILED;
                if (state_q == RECEIVE) begin
                    dv_q <= 1'b1;
                    er_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    LINK_FAILED: begin
                        state_q <= WAIT_FOR_K;
                    end
                    WAIT_FOR_K: begin
                        if (isIdleK && evenFlag) begin
                            state_q <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (evenFlag) begin
                            if (isStart) begin
                                state_q <= RECEIVE;
                                dv_q    <= 1'b1;
                                rxd_q   <= RXD_PREAMBLE;
                            end else if (!isIdleK) begin
                                state_q <= FALSE_CARRIER;
                                er_q    <= 1'b1;
                                rxd_q   <= RXD_FALSE_CARR;
                            end
                        end else if (isIdleK) begin
                            state_q <= FALSE_CARRIER;
                            er_q    <= 1'b1;
                            rxd_q   <= RXD_FALSE_CARR;
                        end
                    end
                    FALSE_CARRIER: begin
                        if (isIdleK && evenFlag) begin
                            state_q <= IDLE;
                        end else begin
                            er_q  <= 1'b1;
                            rxd_q <= RXD_FALSE_CARR;
                        end
                    end
                    RECEIVE: begin
                        if (isData) begin
                            dv_q  <= 1'b1;
                            rxd_q <= octet;
                        end else if (isTerm) begin
                            state_q <= TRR_EXTEND;
                        end else if (isIdleK && evenFlag) begin
                            state_q <= EARLY_END;
                            dv_q    <= 1'b1;
                            er_q    <= 1'b1;
                        end else begin
                            dv_q <= 1'b1;
                            er_q <= 1'b1;
                        end
                    end
                    EARLY_END: begin
                        state_q <= IDLE;
                    end
                    TRR_EXTEND: begin
                        if (isExtend) begin
                            er_q  <= 1'b1;
                            rxd_q <= RXD_CARR_EXT;
                        end else if (isIdleK && evenFlag) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= IDLE;
                            er_q    <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= LINK_FAILED;
                    end
                endcase
            end
        end
    end

    // Output delay line: shifts the FSM emission through PIPE stages unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE; i++) begin
                dvPipe_q[i]  <= 1'b0;
                erPipe_q[i]  <= 1'b0;
                rxdPipe_q[i] <= 8'h00;
            end
        end else begin
            dvPipe_q[0]  <= dv_q;
            erPipe_q[0]  <= er_q;
            rxdPipe_q[0] <= rxd_q;
            for (int i = 1; i < PIPE; i++) begin
                dvPipe_q[i]  <= dvPipe_q[i-1];
                erPipe_q[i]  <= erPipe_q[i-1];
                rxdPipe_q[i] <= rxdPipe_q[i-1];
            end
        end
    end

    assign RX_DV = dvPipe_q[PIPE-1];
    assign RX_ER = erPipe_q[PIPE-1];
    assign RXD   = rxdPipe_q[PIPE-1];

`ifdef PCS_RX_STATS_EN

    logic             frameEndNow;
    logic             fend_q;
    logic             fendPipe_q [PIPE];
    logic [CNT_W-1:0] frameCnt_q;
    logic [CNT_W-1:0] frameCnt_d;
    logic [CNT_W-1:0] errCnt_q;
    logic [CNT_W-1:0] errCnt_d;

    assign frameEndNow = sync_status && (state_q == RECEIVE) && isTerm;

    // Frame-end marker, timed like the emission so the counter moves with the visible outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fend_q <= 1'b0;
            for (int i = 0; i < PIPE; i++) begin
                fendPipe_q[i] <= 1'b0;
            end
        end else begin
            fend_q        <= frameEndNow;
            fendPipe_q[0] <= fend_q;
            for (int i = 1; i < PIPE; i++) begin
                fendPipe_q[i] <= fendPipe_q[i-1];
            end
        end
    end

    // Saturating next values: both counters stop at all-ones
    always_comb begin
        frameCnt_d = frameCnt_q;
        errCnt_d   = errCnt_q;
        if (fendPipe_q[PIPE-1] && (frameCnt_q != {CNT_W{1'b1}})) begin
            frameCnt_d = frameCnt_q + CNT_W'(1);
        end
        if (erPipe_q[PIPE-1] && (errCnt_q != {CNT_W{1'b1}})) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else begin
            frameCnt_q <= frameCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign frame_count = frameCnt_q;
    assign error_count = errCnt_q;

`else

    assign frame_count = '0;
    assign error_count = '0;

`endif

endmodule

// File: doc/pcs_receive_pipe.md
PCS_RECEIVE_PIPE -- requirements
Module: pcs_receive_pipe

Interface
REQ-001 SHALL have parameter PIPE, default 1: output register stages, legal 1..4.
REQ-002 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sync_status  input  1  1 = code-group alignment acquired.
REQ-006 SHALL have port SUDI  input  11  [10] EVEN flag, [9] invalid code-group, [8] K flag, [7:0] decoded octet.
REQ-007 SHALL have port RX_DV  output  1  GMII receive data valid.
REQ-008 SHALL have port RX_ER  output  1  GMII receive error.
REQ-009 SHALL have port RXD  output  8  GMII receive octet.
REQ-010 SHALL have port frame_count  output  CNT_W  frames ended by /T/.
REQ-011 SHALL have port error_count  output  CNT_W  RX_ER assertion cycles.

Function
REQ-012 Code notation: /K/ = K,0xBC; /S/ = K,0xFB; /T/ = K,0xFD; /R/ = K,0xF7; /D/ = data with invalid=0 and K=0.
REQ-013 FSM states SHALL be LINK_FAILED, WAIT_FOR_K, IDLE, RECEIVE, EARLY_END, TRR_EXTEND, FALSE_CARRIER.
REQ-014 sync_status=0 in any state SHALL force LINK_FAILED next cycle; LINK_FAILED -> WAIT_FOR_K when sync_status=1.
REQ-015 WAIT_FOR_K -> IDLE on /K/ with EVEN=1; other code-groups SHALL keep WAIT_FOR_K.
REQ-016 IDLE: /S/ with EVEN=1 -> RECEIVE, emitting RX_DV=1, RXD=0x55 (preamble substitution).
REQ-017 IDLE: any non-/K/ other than /S/, or a /K/ with EVEN=0 -> FALSE_CARRIER, emitting RX_ER=1, RXD=0x0E, RX_DV=0; remain until /K/ with EVEN=1, then IDLE.
REQ-018 RECEIVE: /D/ SHALL emit RX_DV=1, RXD=octet, RX_ER=0.
REQ-019 RECEIVE: invalid or unexpected K (not /T/) SHALL emit RX_DV=1, RX_ER=1, RXD=0x00, staying in RECEIVE.
REQ-020 RECEIVE: /T/ -> TRR_EXTEND, emitting RX_DV=0, RX_ER=0; frame_count increments once.
REQ-021 TRR_EXTEND: /R/ SHALL emit RX_ER=1, RXD=0x0F (carrier extend); /K/ with EVEN=1 -> IDLE; other codes -> IDLE with RX_ER=1 for that cycle.
REQ-022 RECEIVE: /K/ with EVEN=1 (idle without /T/) -> EARLY_END, emitting RX_DV=1, RX_ER=1 for one cycle, then IDLE with RX_DV=0.
REQ-023 Leaving RECEIVE via sync_status=0 SHALL emit RX_DV=1, RX_ER=1 for one cycle, then RX_DV=0, RX_ER=0.
REQ-024 Outputs not otherwise specified SHALL be RX_DV=0, RX_ER=0, RXD=0x00.
REQ-025 Latency: outputs for the SUDI sampled at edge n SHALL appear after edge n+PIPE, unchanged across the pipeline.
REQ-026 error_count SHALL increment on every cycle the emitted RX_ER is 1.
REQ-027 Counters SHALL saturate at 2^CNT_W-1, never wrap.

Reset
REQ-028 reset=0 SHALL immediately force LINK_FAILED, clear all pipeline stages, and drive RX_DV=0, RX_ER=0, RXD=0x00, counters=0.
REQ-029 Reset assertion mid-frame SHALL drop RX_DV without an RX_ER cycle; release SHALL require WAIT_FOR_K and /K/ again before any frame is accepted.

Configuration
REQ-030 Macro PCS_RX_STATS_EN defined: frame_count and error_count SHALL behave per REQ-020, REQ-026, REQ-027.
REQ-031 Macro PCS_RX_STATS_EN undefined: counters SHALL be absent from logic, and the counter ports SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-032 Reset low, sync_status=1, then 4x /K/+D0x50 alternating EVEN=1/0, then /S/, D0x11, D0x22, /T/, /R/, /K/ -> RX_DV high for 3 cycles, RXD 0x55,0x11,0x22, PIPE cycles later; frame_count=1.
REQ-033 Mid-frame SUDI[9]=1 -> that cycle RX_DV=1, RX_ER=1, RXD=0x00; error_count=1; frame continues.
REQ-034 Mid-frame /K/ on EVEN without /T/ -> one cycle RX_DV=1, RX_ER=1, then RX_DV=0; frame_count unchanged.
REQ-035 In IDLE, D0x33 on EVEN -> RX_ER=1, RXD=0x0E, RX_DV=0 until the next /K/ on EVEN.
REQ-036 sync_status dropped mid-frame -> one RX_ER cycle, then no RX_DV until /K/ is received after sync_status returns.
REQ-037 Repeat REQ-032 for PIPE=1 and PIPE=4 -> identical waveforms shifted by 3 cycles; with the macro undefined, counters stay 0.
